multi_ch_divider: RTL and testbench

- Runtime-programmable, multi-channel clock-enable divider; the parametrised successor of the fixed single-channel tick divider.
- Each channel divides `clk` by its own divisor and emits either a one-cycle tick (pulse mode) or a near-50% square enable (square mode).
- Outputs feed waveform-generator phase accumulators, sample-rate strobes and PWM bases.
- Divisor and mode changes apply glitch-free at period boundaries. A global sync clear phase-aligns all channels.

---
 rtl/divider_pkg.sv | 9 +
 rtl/divider_channel.sv | 52 +++++
 rtl/multi_ch_divider.sv | 32 +++
 tb/tb_multi_ch_divider.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared types and helpers for the multi-channel clock-enable divider
package divider_pkg;
  typedef enum logic {DIV_PULSE = 1'b0, DIV_SQUARE = 1'b1} div_mode_e;
  localparam int DIV_MAX_CH = 16;
  // ceil(d/2) without needing a wider adder: (d>>1) plus the dropped LSB
  function automatic logic [31:0] half_period(input logic [31:0] d);
    return (d >> 1) + {31'b0, d[0]};
  endfunction
endpackage

// File: rtl/divider_channel.sv
// divider_channel: one divider lane (counter, divisor/mode shadow, registered outputs)
// Ports: clk, rst_n (async, active-low), en (level), mode (0 pulse / 1 square),
//        div (divisor, 0 treated as 1), clr (sync restart), out (divided output), wrap (period tick)
module divider_channel
  import divider_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] div,
  input  logic             clr,
  output logic             out,
  output logic             wrap
);
  logic [CNT_W-1:0] cnt_q, d_act, d_eff, h, cnt_next;
  div_mode_e        mode_act;
  logic             wrap_now, load;
  always_comb begin
    d_eff    = (d_act == '0) ? CNT_W'(1) : d_act;
    h        = CNT_W'(half_period(32'(d_eff)));
    wrap_now = cnt_q == d_eff - 1'b1;
    cnt_next = wrap_now ? '0 : cnt_q + 1'b1;
    // shadow only moves when the counter restarts, so a period is never cut or stretched
    load     = clr | ~en | wrap_now;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      out      <= 1'b0;
      wrap     <= 1'b0;
      d_act    <= CNT_W'(1);
      mode_act <= DIV_PULSE;
    end else begin
      if (clr || !en) begin
        cnt_q <= '0;
        out   <= 1'b0;
        wrap  <= 1'b0;
      end else begin
        cnt_q <= cnt_next;
        wrap  <= wrap_now;
        out   <= (mode_act == DIV_SQUARE) ? (cnt_next < h) : wrap_now;
      end
      if (load) begin
        d_act    <= div;
        mode_act <= div_mode_e'(mode);
      end
    end
  end
endmodule

// File: rtl/multi_ch_divider.sv
// multi_ch_divider: runtime-programmable multi-channel clock-enable divider
// Ports: clk, rst_n (async, active-low), en_i/mode_i (per channel), div_i (CNT_W per channel,
//        channel c at [c*CNT_W +: CNT_W]), sync_clr_i (restart all in phase),
//        out_o (divided output), wrap_o (period tick)
module multi_ch_divider
  import divider_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       mode_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic                    sync_clr_i,
  output logic [NUM_CH-1:0]       out_o,
  output logic [NUM_CH-1:0]       wrap_o
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    divider_channel #(.CNT_W(CNT_W)) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en_i[c]),
      .mode (mode_i[c]),
      .div  (div_i[c*CNT_W +: CNT_W]),
      .clr  (sync_clr_i),
      .out  (out_o[c]),
      .wrap (wrap_o[c])
    );
  end
endmodule

// File: tb/tb_multi_ch_divider.sv
// tb_multi_ch_divider: scoreboard bench for multi_ch_divider against an edge-counting reference model
module tb_multi_ch_divider;
  localparam int N = 4;
  localparam int W = 16;
  typedef struct {
    logic [N-1:0] o;
    logic [N-1:0] w;
  } exp_t;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   en = '0;
  logic [N-1:0]   mode = '0;
  logic [N*W-1:0] div = '0;
  logic           clr = 1'b0;
  logic [N-1:0]   out, wrap;
  int             m_phase[N];
  int             m_d[N];
  bit             m_mode[N];
  exp_t           q[$];
  exp_t           mx;
  int             tests = 0;
  int             fails = 0;
  multi_ch_divider #(.NUM_CH(N), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .mode_i(mode), .div_i(div),
    .sync_clr_i(clr), .out_o(out), .wrap_o(wrap)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_phase[c] = 0;
      m_d[c]     = 1;
      m_mode[c]  = 1'b0;
    end
  endtask
  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    logic [N*W-1:0] v;
    v = {W'(d), W'(c), W'(b), W'(a)};
    return v;
  endfunction
  function automatic logic [N*W-1:0] rnd_div();
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = W'($urandom_range(0, 9));
    return v;
  endfunction
  // Drive one cycle of inputs and push what the outputs must be after the next edge.
  // The model counts enabled edges modulo the divisor latched at the last restart.
  task automatic step(input logic [N-1:0] e, input logic [N-1:0] md, input logic [N*W-1:0] dv, input logic c);
    exp_t x;
    int de, p;
    @(negedge clk);
    en = e; mode = md; div = dv; clr = c;
    x.o = '0; x.w = '0;
    if (!rst_n) model_reset();
    else for (int ch = 0; ch < N; ch++) begin
      de = (m_d[ch] == 0) ? 1 : m_d[ch];
      if (c || !e[ch]) begin
        m_phase[ch] = 0;
        m_d[ch]     = int'(dv[ch*W +: W]);
        m_mode[ch]  = md[ch];
      end else begin
        p = (m_phase[ch] + 1) % de;
        x.w[ch] = (p == 0);
        x.o[ch] = m_mode[ch] ? (p < (de + 1) / 2) : (p == 0);
        m_phase[ch] = p;
        if (p == 0) begin
          m_d[ch]    = int'(dv[ch*W +: W]);
          m_mode[ch] = md[ch];
        end
      end
    end
    q.push_back(x);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mx = q.pop_front();
      tests += 2;
      if (out !== mx.o) begin
        fails++;
        $display("FAIL out_o t=%0t got=%b exp=%b", $time, out, mx.o);
      end
      if (wrap !== mx.w) begin
        fails++;
        $display("FAIL wrap_o t=%0t got=%b exp=%b", $time, wrap, mx.w);
      end
    end
  end
  initial begin
    logic [N-1:0] e, md;
    logic [N*W-1:0] dv;
    model_reset();
    repeat (3) step('0, '0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    // async reset mid-count: square D=7 on all channels, out is high at phase 2
    step('0, '1, pk(7, 7, 7, 7), 1'b0);
    repeat (9) step('1, '1, pk(7, 7, 7, 7), 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (out !== '0 || wrap !== '0) begin
      fails++;
      $display("FAIL async_reset got out=%b wrap=%b exp=0/0", out, wrap);
    end
    model_reset();
    repeat (2) step('1, '1, pk(7, 7, 7, 7), 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) step('0, '0, pk(7, 7, 7, 7), 1'b0);
    // pulse D=4, square D=5 and D=6
    repeat (13) step(4'b0001, '0, pk(4, 5, 6, 2), 1'b0);
    step('0, '1, pk(5, 6, 3, 2), 1'b0);
    repeat (16) step('1, '1, pk(5, 6, 3, 2), 1'b0);
    // divisor change mid-period and mode toggle mid-period
    step('0, 4'b0101, pk(10, 10, 10, 10), 1'b0);
    repeat (4) step('1, 4'b0101, pk(10, 10, 10, 10), 1'b0);
    repeat (16) step('1, 4'b1010, pk(3, 3, 3, 3), 1'b0);
    // sync clear with D=4 and D=6 out of phase, then clear landing on a wrap edge
    step(4'b0001, '0, pk(4, 6, 0, 0), 1'b0);
    repeat (7) step(4'b0011, '0, pk(4, 6, 0, 0), 1'b0);
    step(4'b0011, '0, pk(4, 6, 0, 0), 1'b1);
    repeat (25) step(4'b0011, '0, pk(4, 6, 0, 0), 1'b0);
    step(4'b0011, '0, pk(4, 6, 0, 0), 1'b1);
    repeat (3) step(4'b0011, '0, pk(4, 6, 0, 0), 1'b0);
    step(4'b0011, '0, pk(4, 6, 0, 0), 1'b1);
    repeat (8) step(4'b0011, '0, pk(4, 6, 0, 0), 1'b0);
    // D=0 and D=1 in both modes
    step('0, 4'b0011, pk(0, 1, 0, 1), 1'b0);
    repeat (6) step('1, 4'b0011, pk(0, 1, 0, 1), 1'b0);
    // full-width divisor on ch3 (square) while the other channels run random traffic
    step('0, 4'b1000, pk(0, 0, 0, 65535), 1'b0);
    repeat (65600) begin
      e = {1'b1, 3'($urandom_range(0, 7) == 0 ? $urandom : 3'b111)};
      md = {1'b1, 3'($urandom)};
      dv = rnd_div();
      dv[3*W +: W] = W'($urandom_range(0, 65535));
      step(e, md, dv, 1'b0);
    end
    // random mix including sync clears and enable drops
    repeat (3000) begin
      e = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
      step(e, N'($urandom), rnd_div(), $urandom_range(0, 19) == 0);
    end
    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
